// File: rtl/serial_word_feeder.sv
// serial_word_feeder
// Parallel-to-serial front end for the bit-serial detectors. WIDTH-bit words
// arrive over valid/ready and are shifted out one bit per clock on serial_o.
// A single holding register lets the next word wait while the current one
// shifts, so a continuous stream is serialized with no idle bit between words.
//
// Handshake: a word transfers on every rising edge where valid_i & ready_o.
// ready_o depends only on registers (and reset), never on valid_i. Once
// valid_i is raised, the upstream keeps data_i and valid_i stable until that
// transfer edge.
//
// Ports:
//   clk            single clock, rising edge
//   reset          asynchronous active-low reset (0 = in reset)
//   data_i         word to serialize, sampled on a transfer edge
//   valid_i        data_i holds a valid word
//   ready_o        block can accept a word this cycle
//   serial_o       current serial bit (registered)
//   serial_valid_o serial_o carries a word bit (registered)
//   first_o        current bit is the first bit of a word (registered)
//   last_o         current bit is the last bit of a word (registered)
//   busy_o         shifter active or holding register full
//   state_o        FSM state for debug (0 = IDLE, 1 = SHIFT)
module serial_word_feeder #(
  parameter int WIDTH     = 8,
  parameter bit LSB_FIRST = 1'b0,
  parameter bit IDLE_BIT  = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_i,
  input  logic             valid_i,
  output logic             ready_o,
  output logic             serial_o,
  output logic             serial_valid_o,
  output logic             first_o,
  output logic             last_o,
  output logic             busy_o,
  output logic             state_o
);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   shift_q, shift_d;
  logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0]   bit_cnt_inc;
  logic [WIDTH-1:0]   hold_data_q, hold_data_d;
  logic               hold_full_q, hold_full_d;
  logic               serial_q, serial_d;
  logic               sv_q, sv_d;
  logic               first_q, first_d;
  logic               last_q, last_d;

  logic               accept;
  logic               load_edge;
  logic               do_load;
  logic [WIDTH-1:0]   load_word;

  assign ready_o     = reset & ~hold_full_q;
  assign accept      = valid_i & ready_o;
  // A new word may start whenever nothing is shifting or the last bit is out.
  assign load_edge   = (state_q == S_IDLE) | (bit_cnt_q == LAST_IDX);
  assign do_load     = load_edge & (hold_full_q | accept);
  // The held word is older than anything arriving now, so it goes first.
  assign load_word   = hold_full_q ? hold_data_q : data_i;
  assign bit_cnt_inc = bit_cnt_q + CNT_ONE;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (load_edge) begin
      state_d = do_load ? S_SHIFT : S_IDLE;
    end
  end

  // Output / datapath next values
  always_comb begin
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    hold_data_d = hold_data_q;
    hold_full_d = hold_full_q;
    serial_d    = serial_q;
    sv_d        = sv_q;
    first_d     = first_q;
    last_d      = last_q;

    if (load_edge) begin
      if (do_load) begin
        shift_d   = load_word;
        bit_cnt_d = '0;
        serial_d  = LSB_FIRST ? load_word[0] : load_word[WIDTH-1];
        sv_d      = 1'b1;
        first_d   = 1'b1;
        last_d    = 1'b0;
        if (hold_full_q) begin
          // Hold drains into the shifter; a same-edge arrival refills it.
          hold_full_d = accept;
          if (accept) begin
            hold_data_d = data_i;
          end
        end
      end else begin
        bit_cnt_d = '0;
        serial_d  = IDLE_BIT;
        sv_d      = 1'b0;
        first_d   = 1'b0;
        last_d    = 1'b0;
      end
    end else begin
      // Mid-word: present the next bit and park any arriving word in hold.
      if (LSB_FIRST) begin
        shift_d  = shift_q >> 1;
        serial_d = shift_q[1];
      end else begin
        shift_d  = shift_q << 1;
        serial_d = shift_q[WIDTH-2];
      end
      bit_cnt_d = bit_cnt_inc;
      first_d   = 1'b0;
      last_d    = (bit_cnt_inc == LAST_IDX);
      if (accept) begin
        hold_data_d = data_i;
        hold_full_d = 1'b1;
      end
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      hold_data_q <= '0;
      hold_full_q <= 1'b0;
      serial_q    <= IDLE_BIT;
      sv_q        <= 1'b0;
      first_q     <= 1'b0;
      last_q      <= 1'b0;
    end else begin
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      hold_data_q <= hold_data_d;
      hold_full_q <= hold_full_d;
      serial_q    <= serial_d;
      sv_q        <= sv_d;
      first_q     <= first_d;
      last_q      <= last_d;
    end
  end

  assign serial_o       = serial_q;
  assign serial_valid_o = sv_q;
  assign first_o        = first_q;
  assign last_o         = last_q;
  assign busy_o         = (state_q == S_SHIFT) | hold_full_q;
  assign state_o        = state_q;

endmodule

// File: tb/tb_serial_word_feeder.sv
// Bench for serial_word_feeder: one MSB-first instance (IDLE_BIT=0) checked
// every cycle against a queue-based reference model, plus an LSB-first
// instance (IDLE_BIT=1) checked against a table of hand-derived bit sequences.
module tb_serial_word_feeder;
  localparam int W = 8;

  // Clock / reset
  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  // MSB-first instance
  logic [W-1:0] data  = '0;
  logic         valid = 1'b0;
  logic ready, ser, sv, first, last, busy, st;

  // LSB-first instance
  logic [W-1:0] data_l  = '0;
  logic         valid_l = 1'b0;
  logic ready_l, ser_l, sv_l, first_l, last_l, busy_l, st_l;

  serial_word_feeder #(.WIDTH(W), .LSB_FIRST(1'b0), .IDLE_BIT(1'b0)) dut (
    .clk(clk), .reset(reset), .data_i(data), .valid_i(valid),
    .ready_o(ready), .serial_o(ser), .serial_valid_o(sv),
    .first_o(first), .last_o(last), .busy_o(busy), .state_o(st)
  );

  serial_word_feeder #(.WIDTH(W), .LSB_FIRST(1'b1), .IDLE_BIT(1'b1)) dut_l (
    .clk(clk), .reset(reset), .data_i(data_l), .valid_i(valid_l),
    .ready_o(ready_l), .serial_o(ser_l), .serial_valid_o(sv_l),
    .first_o(first_l), .last_o(last_l), .busy_o(busy_l), .state_o(st_l)
  );

  int vec_cnt = 0;
  int err_cnt = 0;

  // Reference model: bits still to be shown for the current word (front is
  // the bit on serial_o now) and words waiting for the shifter (capacity 1).
  logic         cur_q[$];
  logic [W-1:0] pend_q[$];
  int sv_run = 0;
  int sv_max = 0;

  typedef struct {
    logic [W-1:0] word;
    logic [W-1:0] msb_seq;  // transmission order, leftmost bit first
    logic [W-1:0] lsb_seq;
  } vec_t;
  vec_t tbl[6];

  // Expected {ready, serial, serial_valid, first, last, busy}
  function automatic logic [5:0] model_out();
    logic r, s, v, f, l, b;
    r = reset && (pend_q.size() == 0);
    if (cur_q.size() > 0) begin
      s = cur_q[0];
      v = 1'b1;
      f = (cur_q.size() == W);
      l = (cur_q.size() == 1);
    end else begin
      s = 1'b0; v = 1'b0; f = 1'b0; l = 1'b0;
    end
    b = (cur_q.size() > 0) || (pend_q.size() > 0);
    return {r, s, v, f, l, b};
  endfunction

  task automatic check_vec(input string name, input logic [5:0] act, input logic [5:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %b want %b (ready,ser,sv,first,last,busy) t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %b want %b t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    vec_cnt++;
    if (act != exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d want %0d t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic load_bits(input logic [W-1:0] w);
    for (int i = W - 1; i >= 0; i--) cur_q.push_back(w[i]);
  endtask

  // One clock: predict the transfer, step the model at the edge, compare on
  // the falling edge.
  task automatic tick(output logic acc);
    logic [W-1:0] nxt;
    acc = valid && reset && (pend_q.size() == 0);
    @(posedge clk);
    if (reset) begin
      if (cur_q.size() <= 1) begin
        if (cur_q.size() == 1) void'(cur_q.pop_front());
        if (pend_q.size() > 0) begin
          nxt = pend_q.pop_front();
          load_bits(nxt);
          if (acc) pend_q.push_back(data);
        end else if (acc) begin
          load_bits(data);
        end
      end else begin
        void'(cur_q.pop_front());
        if (acc) pend_q.push_back(data);
      end
    end
    @(negedge clk);
    check_vec("cycle", {ready, ser, sv, first, last, busy}, model_out());
    if (sv) sv_run++; else sv_run = 0;
    if (sv_run > sv_max) sv_max = sv_run;
  endtask

  task automatic idle(input int n);
    logic d;
    for (int i = 0; i < n; i++) tick(d);
  endtask

  // Offer a word and wait (bounded) for it to transfer.
  task automatic send(input logic [W-1:0] w);
    logic got;
    got = 1'b0;
    data = w;
    valid = 1'b1;
    for (int i = 0; i < 64 && !got; i++) tick(got);
    if (!got) begin
      err_cnt++;
      vec_cnt++;
      $display("FAIL send_timeout: word %h not accepted within 64 cycles", w);
    end
    valid = 1'b0;
  endtask

  initial begin
    logic got;

    tbl[0] = '{8'hA5, 8'b1010_0101, 8'b1010_0101};
    tbl[1] = '{8'h01, 8'b0000_0001, 8'b1000_0000};
    tbl[2] = '{8'h3C, 8'b0011_1100, 8'b0011_1100};
    tbl[3] = '{8'h0F, 8'b0000_1111, 8'b1111_0000};
    tbl[4] = '{8'hC8, 8'b1100_1000, 8'b0001_0011};
    tbl[5] = '{8'h81, 8'b1000_0001, 8'b1000_0001};

    // Reset state
    @(negedge clk);
    check_vec("reset_msb", {ready, ser, sv, first, last, busy}, 6'b000000);
    check_vec("reset_lsb", {ready_l, ser_l, sv_l, first_l, last_l, busy_l}, 6'b010000);
    idle(1);
    #2 reset = 1'b1;
    #1 check_vec("release_msb", {ready, ser, sv, first, last, busy}, 6'b100000);
    check_vec("release_lsb", {ready_l, ser_l, sv_l, first_l, last_l, busy_l}, 6'b110000);
    @(negedge clk);
    idle(2);

    // Single word
    send(8'hA5);
    idle(10);

    // Stream with valid held high
    sv_max = 0;
    send(8'hA5); send(8'h3C); send(8'hFF);
    idle(30);
    check_int("stream_run", sv_max, 24);

    // Backpressure
    sv_max = 0;
    send(8'h01);
    send(8'h02);
    check_bit("bp_ready_low", ready, 1'b0);
    check_bit("bp_busy", busy, 1'b1);
    send(8'h03);
    idle(30);
    check_int("bp_run", sv_max, 24);

    // Bypass on the last_o cycle
    send(8'h5A);
    for (int i = 0; i < 16 && !last; i++) tick(got);
    check_bit("bypass_at_last", last, 1'b1);
    data = 8'h81;
    valid = 1'b1;
    tick(got);
    valid = 1'b0;
    check_bit("bypass_acc", got, 1'b1);
    check_bit("bypass_first", first, 1'b1);
    check_bit("bypass_bit7", ser, 1'b1);
    check_bit("bypass_ready", ready, 1'b1);
    idle(12);

    // Reset mid-word with a word held
    send(8'hA5);
    send(8'h3C);
    idle(3);
    #2 reset = 1'b0;
    cur_q.delete();
    pend_q.delete();
    #1 check_vec("rst_async", {ready, ser, sv, first, last, busy}, 6'b000000);
    @(negedge clk);
    idle(1);
    #2 reset = 1'b1;
    #1 check_vec("rst_release", {ready, ser, sv, first, last, busy}, 6'b100000);
    @(negedge clk);
    idle(4);
    send(8'h0F);
    idle(10);

    // Table: both instances, one word each
    for (int t = 0; t < 6; t++) begin
      data = tbl[t].word;   valid = 1'b1;
      data_l = tbl[t].word; valid_l = 1'b1;
      tick(got);
      valid = 1'b0; valid_l = 1'b0;
      check_bit("tbl_acc", got, 1'b1);
      for (int k = 0; k < W; k++) begin
        check_bit("tbl_lsb_ser", ser_l, tbl[t].lsb_seq[W-1-k]);
        check_vec("tbl_lsb_flags", {ready_l, 1'b0, sv_l, first_l, last_l, busy_l},
                  {1'b1, 1'b0, 1'b1, logic'(k == 0), logic'(k == W - 1), 1'b1});
        check_bit("tbl_msb_ser", ser, tbl[t].msb_seq[W-1-k]);
        tick(got);
      end
      check_vec("tbl_lsb_idle", {ready_l, ser_l, sv_l, first_l, last_l, busy_l}, 6'b110000);
    end

    // Random traffic against the model
    for (int n = 0; n < 600; n++) begin
      tick(got);
      if (got) valid = 1'b0;
      if (!valid && $urandom_range(0, 2) != 0) begin
        valid = 1'b1;
        data = W'($urandom);
      end
    end
    valid = 1'b0;
    idle(20);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
